// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM state codes, trap codes and ALU functions for stack_cpu_core
package cpu_pkg;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_PUSHI = 6'h01;
    localparam logic [5:0] OP_LOAD  = 6'h02;
    localparam logic [5:0] OP_STORE = 6'h03;
    localparam logic [5:0] OP_ADD   = 6'h04;
    localparam logic [5:0] OP_SUB   = 6'h05;
    localparam logic [5:0] OP_AND   = 6'h06;
    localparam logic [5:0] OP_OR    = 6'h07;
    localparam logic [5:0] OP_XOR   = 6'h08;
    localparam logic [5:0] OP_JMP   = 6'h09;
    localparam logic [5:0] OP_JZ    = 6'h0A;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_POP_B  = 4'd2;
    localparam logic [3:0] ST_POP_A  = 4'd3;
    localparam logic [3:0] ST_EXEC   = 4'd4;
    localparam logic [3:0] ST_PUSH   = 4'd5;
    localparam logic [3:0] ST_LOAD   = 4'd6;
    localparam logic [3:0] ST_STORE  = 4'd7;
    localparam logic [3:0] ST_HALT   = 4'd8;
    localparam logic [3:0] ST_ERROR  = 4'd9;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

    // ALU function = opcode - OP_ADD
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

endpackage

// File: rtl/stack_alu.sv
// rtl/stack_alu.sv - combinational two-operand ALU for stack_cpu_core
module stack_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        i_func,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_func)
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/stack_cpu_core.sv
// rtl/stack_cpu_core.sv - multicycle stack-machine core with one shared req/ready memory port
module stack_cpu_core
    import cpu_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] STACK_TOP   = 'h00FE,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 'h0080,
    parameter logic [ADDR_W-1:0] ENTRY       = 'h0020
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_halted,
    output logic              o_error,
    output logic [1:0]        o_err_code
);

    localparam int                IMM_W    = DATA_W - 6;
    localparam logic [ADDR_W-1:0] SP_EMPTY = STACK_TOP + 1'b1;

    logic [3:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_sp;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_halted;
    logic              r_error;
    logic [1:0]        r_err_code;

    logic [3:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_sp_nxt;
    logic [DATA_W-1:0] w_ir_nxt;
    logic [DATA_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_b_nxt;
    logic [DATA_W-1:0] w_res_nxt;
    logic [1:0]        w_err_nxt;
    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;

    logic              w_done;
    logic [5:0]        w_op;
    logic [IMM_W-1:0]  w_imm;
    logic [ADDR_W-1:0] w_imm_addr;
    logic [DATA_W-1:0] w_imm_data;
    logic [2:0]        w_alu_func;
    logic [DATA_W-1:0] w_alu_y;

    assign w_done     = r_mem_req & i_mem_ready;
    assign w_op       = r_ir[DATA_W-1 -: 6];
    assign w_imm      = r_ir[IMM_W-1:0];
    assign w_imm_addr = ADDR_W'(w_imm);
    assign w_imm_data = DATA_W'(w_imm);
    assign w_alu_func = 3'(w_op - OP_ADD);

    stack_alu #(.DATA_W(DATA_W)) u_alu (
        .i_func (w_alu_func),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_y    (w_alu_y)
    );

    // Stack traps are raised in DECODE so a faulting instruction never touches memory.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_ir_nxt    = r_ir;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_res_nxt   = r_res;
        w_err_nxt   = r_err_code;
        case (r_state)
            ST_FETCH: if (w_done) begin
                w_ir_nxt    = i_mem_rdata;
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: case (w_op)
                OP_NOP: w_state_nxt = ST_FETCH;
                OP_PUSHI, OP_LOAD: begin
                    if (r_sp == STACK_LIMIT) begin
                        w_err_nxt   = ERR_OVERFLOW;
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_res_nxt   = w_imm_data;
                        w_state_nxt = (w_op == OP_LOAD) ? ST_LOAD : ST_PUSH;
                    end
                end
                OP_STORE, OP_JZ: begin
                    if (r_sp == SP_EMPTY) begin
                        w_err_nxt   = ERR_UNDERFLOW;
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_state_nxt = ST_POP_A;
                    end
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    if (r_sp == SP_EMPTY || r_sp == STACK_TOP) begin
                        w_err_nxt   = ERR_UNDERFLOW;
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_state_nxt = ST_POP_B;
                    end
                end
                OP_JMP: begin
                    w_pc_nxt    = w_imm_addr;
                    w_state_nxt = ST_FETCH;
                end
                OP_HALT: w_state_nxt = ST_HALT;
                default: begin
                    w_err_nxt   = ERR_ILLEGAL;
                    w_state_nxt = ST_ERROR;
                end
            endcase
            ST_POP_B: if (w_done) begin
                w_b_nxt     = i_mem_rdata;
                w_sp_nxt    = r_sp + 1'b1;
                w_state_nxt = ST_POP_A;
            end
            ST_POP_A: if (w_done) begin
                w_a_nxt  = i_mem_rdata;
                w_sp_nxt = r_sp + 1'b1;
                if (w_op == OP_STORE) begin
                    w_state_nxt = ST_STORE;
                end else if (w_op == OP_JZ) begin
                    if (i_mem_rdata == '0) w_pc_nxt = w_imm_addr;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_res_nxt   = w_alu_y;
                w_state_nxt = ST_PUSH;
            end
            ST_LOAD: if (w_done) begin
                w_res_nxt   = i_mem_rdata;
                w_state_nxt = ST_PUSH;
            end
            ST_PUSH: if (w_done) begin
                w_sp_nxt    = r_sp - 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_STORE: if (w_done) w_state_nxt = ST_FETCH;
            default: w_state_nxt = r_state;
        endcase
    end

    // Bus outputs are a registered function of the next state, so they hold while stalled.
    always_comb begin
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
        case (w_state_nxt)
            ST_FETCH: begin
                w_req_nxt  = 1'b1;
                w_addr_nxt = w_pc_nxt;
            end
            ST_POP_A, ST_POP_B: begin
                w_req_nxt  = 1'b1;
                w_addr_nxt = w_sp_nxt;
            end
            ST_LOAD: begin
                w_req_nxt  = 1'b1;
                w_addr_nxt = w_imm_addr;
            end
            ST_PUSH: begin
                w_req_nxt   = 1'b1;
                w_we_nxt    = 1'b1;
                w_addr_nxt  = w_sp_nxt - 1'b1;
                w_wdata_nxt = w_res_nxt;
            end
            ST_STORE: begin
                w_req_nxt   = 1'b1;
                w_we_nxt    = 1'b1;
                w_addr_nxt  = w_imm_addr;
                w_wdata_nxt = w_a_nxt;
            end
            default: w_req_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_FETCH;
            r_pc        <= ENTRY;
            r_sp        <= SP_EMPTY;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_halted    <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_sp        <= w_sp_nxt;
            r_ir        <= w_ir_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_res       <= w_res_nxt;
            r_mem_req   <= w_req_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_halted    <= (w_state_nxt == ST_HALT);
            r_error     <= (w_state_nxt == ST_ERROR);
            r_err_code  <= w_err_nxt;
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_halted    = r_halted;
    assign o_error     = r_error;
    assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_stack_cpu_core.sv
// tb/tb_stack_cpu_core.sv - randomized bench for stack_cpu_core against a program-level reference model
module tb_stack_cpu_core;

    localparam int CAP = 127;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        halted;
    logic        error;
    logic [1:0]  err_code;

    stack_cpu_core dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_ready (mem_ready),
        .i_mem_rdata (mem_rdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_halted    (halted),
        .o_error     (error),
        .o_err_code  (err_code)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit [15:0]   mem  [65536];
    bit [15:0]   mmem [1024];
    logic [15:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
    bit          stall_en = 1'b0;
    bit          mem_hold = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit [15:0] mk(input bit [5:0] op, input int imm);
        return {op, 10'(imm)};
    endfunction

    // Memory responder: random ready stalls, write capture, hold-stability checks.
    initial begin
        bit        pend = 0, p_req = 0, p_rdy = 0, p_we = 0, rdy;
        bit [15:0] p_addr = 0, p_wdata = 0;
        int        wait_cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0; p_req = 0; p_rdy = 0; wait_cnt = 0;
                mem_ready = 1'b0;
            end else begin
                if (p_req && p_rdy) begin
                    if (p_we) begin
                        mem[p_addr] = p_wdata;
                        got_a.push_back(p_addr);
                        got_d.push_back(p_wdata);
                    end
                end else if (p_req) begin
                    check_eq("hold", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, p_we, p_addr, p_wdata});
                end
                if (mem_req) begin
                    if (!pend) begin
                        pend = 1;
                        wait_cnt = stall_en ? int'($urandom_range(0, 4)) : 0;
                    end
                    if (mem_hold) rdy = 0;
                    else if (wait_cnt == 0) begin rdy = 1; pend = 0; end
                    else begin rdy = 0; wait_cnt--; end
                    mem_rdata = mem_we ? 16'($urandom) : mem[mem_addr];
                end else begin
                    rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    mem_rdata = 16'($urandom);
                    pend = 0;
                end
                mem_ready = rdy;
                p_req = mem_req; p_rdy = rdy & mem_req; p_we = mem_we;
                p_addr = mem_addr; p_wdata = mem_wdata;
            end
        end
    end

    // Program-level model: stack depth counter over a flat memory image.
    task automatic model(output bit m_halt, output bit [1:0] m_code);
        int pc, depth;
        bit [15:0] ins, a, b, v;
        bit [5:0]  op;
        bit [9:0]  imm;
        pc = 'h20; depth = 0; m_halt = 0; m_code = 0;
        exp_a.delete(); exp_d.delete();
        for (int step = 0; step < 4000; step++) begin
            ins = mmem[pc]; pc = pc + 1; op = ins[15:10]; imm = ins[9:0];
            case (op)
                6'h00: ;
                6'h01, 6'h02: begin
                    if (depth == CAP) begin m_code = 2; return; end
                    v = (op == 6'h01) ? 16'(imm) : mmem[imm];
                    depth++;
                    mmem['hFF - depth] = v; exp_a.push_back(16'('hFF - depth)); exp_d.push_back(v);
                end
                6'h03: begin
                    if (depth == 0) begin m_code = 3; return; end
                    v = mmem['hFF - depth]; depth--;
                    mmem[imm] = v; exp_a.push_back(16'(imm)); exp_d.push_back(v);
                end
                6'h04, 6'h05, 6'h06, 6'h07, 6'h08: begin
                    if (depth < 2) begin m_code = 3; return; end
                    b = mmem['hFF - depth]; depth--;
                    a = mmem['hFF - depth]; depth--;
                    case (op)
                        6'h04:   v = a + b;
                        6'h05:   v = a - b;
                        6'h06:   v = a & b;
                        6'h07:   v = a | b;
                        default: v = a ^ b;
                    endcase
                    depth++;
                    mmem['hFF - depth] = v; exp_a.push_back(16'('hFF - depth)); exp_d.push_back(v);
                end
                6'h09: pc = int'(imm);
                6'h0A: begin
                    if (depth == 0) begin m_code = 3; return; end
                    v = mmem['hFF - depth]; depth--;
                    if (v == 0) pc = int'(imm);
                end
                6'h3F: begin m_halt = 1; return; end
                default: begin m_code = 1; return; end
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 1024; k++) mem[k] = '0;
    endtask

    task automatic run_prog(input string name, input bit stall, output int cycles);
        bit m_halt, done, seen;
        bit [1:0] m_code;
        int n;
        for (int k = 0; k < 1024; k++) mmem[k] = mem[k];
        model(m_halt, m_code);
        stall_en = stall;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        got_a.delete(); got_d.delete();
        rst = 1'b0;
        cycles = 0; done = 0;
        while (!done && cycles < 6000) begin
            @(negedge clk);
            cycles++;
            if (halted || error) done = 1;
        end
        check_eq({name, "_finished"}, done, 1);
        check_eq({name, "_halted"}, halted, m_halt);
        check_eq({name, "_error"}, error, m_code != 0);
        check_eq({name, "_err_code"}, err_code, m_code);
        check_eq({name, "_nwrites"}, got_a.size(), exp_a.size());
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_wr%0d", name, i), {got_a[i], got_d[i]}, {exp_a[i], exp_d[i]});
        seen = 0;
        repeat (6) @(negedge clk) if (mem_req) seen = 1;
        check_eq({name, "_req_after_stop"}, seen, 0);
    endtask

    task automatic gen_random(input int len);
        int depth, r;
        clear_mem();
        for (int k = 'h40; k < 'h60; k++) mem[k] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        depth = 0;
        for (int i = 0; i < len; i++) begin
            r = int'($urandom_range(0, 99));
            if ((depth < 2 && r < 60) || r < 30) begin
                mem['h20 + i] = mk(6'h01, int'($urandom_range(0, 1023))); depth++;
            end else if (r < 55) begin
                mem['h20 + i] = mk(6'(4 + $urandom_range(0, 4)), 0); depth--;
            end else if (r < 65) begin
                mem['h20 + i] = mk(6'h02, 'h40 + int'($urandom_range(0, 31))); depth++;
            end else if (r < 75) begin
                mem['h20 + i] = mk(6'h03, 'h40 + int'($urandom_range(0, 31))); depth--;
            end else if (r < 82) begin
                mem['h20 + i] = mk(6'h0A, 'h20 + int'($urandom_range(i + 1, len))); depth--;
            end else if (r < 87) begin
                mem['h20 + i] = mk(6'h09, 'h20 + int'($urandom_range(i + 1, len)));
            end else if (r < 93) begin
                mem['h20 + i] = mk(6'h00, 0);
            end else if (r < 96) begin
                mem['h20 + i] = mk(6'($urandom_range('h0B, 'h3E)), 0);
            end else begin
                mem['h20 + i] = mk(6'h01, int'($urandom_range(0, 1023))); depth++;
            end
            if (depth < 0) depth = 0;
        end
        mem['h20 + len] = mk(6'h3F, 0);
    endtask

    initial begin
        int cyc, w;
        rst = 1'b1;
        clear_mem();
        repeat (3) @(negedge clk);
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_bus", {mem_we, mem_addr, mem_wdata}, 0);
        check_eq("rst_flags", {halted, error, err_code}, 0);

        // Reset while a fetch is stalled: request must drop without waiting for a clock.
        rst = 1'b0;
        w = 0;
        while (!mem_req && w < 5) begin @(negedge clk); w++; end
        check_eq("fetch_req", mem_req, 1);
        check_eq("entry_addr", {mem_we, mem_addr}, {1'b0, 16'h0020});
        #2 rst = 1'b1;
        #1 check_eq("rst_drop", mem_req, 0);
        @(negedge clk); rst = 1'b0;
        w = 0;
        while (!mem_req && w < 5) begin @(negedge clk); w++; end
        check_eq("entry_addr2", {mem_req, mem_addr}, {1'b1, 16'h0020});
        mem_hold = 1'b0;

        // PUSHI 5, PUSHI 3, SUB, STORE 0x40, then PUSHI 7 lands at 0xFE only if SP returned to 0xFF.
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            mem['h20] = mk(6'h01, 5);
            mem['h21] = mk(6'h01, 3);
            mem['h22] = mk(6'h05, 0);
            mem['h23] = mk(6'h03, 'h40);
            mem['h24] = mk(6'h01, 7);
            mem['h25] = mk(6'h3F, 0);
            run_prog(pass == 0 ? "sub" : "sub_stall", pass == 1, cyc);
            if (got_a.size() >= 5) begin
                check_eq("store40", {got_a[3], got_d[3]}, {16'h0040, 16'h0002});
                check_eq("sp_restored", {got_a[4], got_d[4]}, {16'h00FE, 16'h0007});
            end else begin
                check_eq("sub_trace_len", got_a.size(), 5);
            end
        end

        clear_mem();
        mem['h20] = mk(6'h01, 1);
        mem['h21] = mk(6'h01, 2);
        mem['h22] = mk(6'h04, 0);
        mem['h23] = mk(6'h3F, 0);
        run_prog("cycles", 0, cyc);
        check_eq("cycle_count", cyc, 1 + 3 + 3 + 6 + 2);

        clear_mem();
        mem['h20] = mk(6'h04, 0);
        mem['h21] = mk(6'h3F, 0);
        run_prog("underflow", 1, cyc);
        check_eq("unf_code", {error, err_code, 8'(got_a.size())}, {1'b1, 2'd3, 8'd0});

        clear_mem();
        mem['h20] = mk(6'h09, 'h100);
        for (int i = 0; i < 128; i++) mem['h100 + i] = mk(6'h01, i + 1);
        mem['h180] = mk(6'h3F, 0);
        run_prog("overflow", 1, cyc);
        check_eq("ovf_code", {error, err_code}, {1'b1, 2'd2});
        check_eq("ovf_writes", got_a.size(), 127);
        if (got_a.size() > 0) check_eq("ovf_last_addr", got_a[got_a.size() - 1], 16'h0080);

        clear_mem();
        mem['h20] = mk(6'h15, 0);
        run_prog("illegal", 0, cyc);
        check_eq("ill_code", {error, err_code}, {1'b1, 2'd1});

        clear_mem();
        mem['h20] = mk(6'h3F, 0);
        run_prog("halt", 0, cyc);
        check_eq("halt_flags", {halted, error, err_code}, {1'b1, 1'b0, 2'd0});

        for (int t = 0; t < 8; t++) begin
            gen_random(int'($urandom_range(10, 28)));
            run_prog($sformatf("rand%0d", t), t[0], cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
